// File: rtl/iomem_pwm_leds.sv
// 8-channel PWM LED controller on the PicoSoC iomem bus.
// Shadowed duty registers load at period wrap so outputs never glitch.
module iomem_pwm_leds #(
  parameter logic [7:0]  BASE_ADDR    = 8'h04,
  parameter logic [15:0] PRESCALE_RST = 16'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic [7:0]  pwm_out,
  output logic        irq
);

  logic        sel;
  logic [5:0]  widx;
  logic [5:0]  dofs;
  logic [2:0]  duty_idx;
  logic        duty_sel;
  logic [2:0]  ctrl;
  logic        en;
  logic        inv;
  logic        irq_en;
  logic [15:0] prescale;
  logic [15:0] pcnt;
  logic [7:0]  cnt;
  logic        wrap_flag;
  logic        tick;
  logic        wrap;
  logic [7:0]  shadow [8];
  logic [7:0]  active [8];
  logic [7:0]  raw;
  logic [31:0] rd_word;
  logic        ctrl_we;
  logic        pre_we0;
  logic        pre_we1;
  logic        stat_clr;
  logic        duty_we;
  logic        unused_bits;

  assign unused_bits = ^{iomem_addr[23:8], iomem_addr[1:0],
                         iomem_wdata[31:16], iomem_wstrb[3:2]};

  assign sel = iomem_valid && !iomem_ready &&
               (iomem_addr[31:24] == BASE_ADDR);
  assign widx     = iomem_addr[7:2];
  assign dofs     = widx - 6'd4;
  assign duty_idx = dofs[2:0];
  assign duty_sel = (widx >= 6'd4) && (widx <= 6'd11);

  assign en     = ctrl[0];
  assign inv    = ctrl[1];
  assign irq_en = ctrl[2];

  assign ctrl_we  = sel && (widx == 6'd0) && iomem_wstrb[0];
  assign pre_we0  = sel && (widx == 6'd1) && iomem_wstrb[0];
  assign pre_we1  = sel && (widx == 6'd1) && iomem_wstrb[1];
  assign stat_clr = sel && (widx == 6'd2) && iomem_wstrb[0] &&
                    iomem_wdata[0];
  assign duty_we  = sel && duty_sel && iomem_wstrb[0];

  // >= lets a shrunken PRESCALE take effect on the very next clock
  assign tick = en && (pcnt >= prescale);
  assign wrap = tick && (cnt == 8'd254);

  assign irq = wrap_flag & irq_en;

  always_comb begin
    rd_word = '0;
    unique case (1'b1)
      widx == 6'd0: rd_word = {29'd0, ctrl};
      widx == 6'd1: rd_word = {16'd0, prescale};
      widx == 6'd2: rd_word = {31'd0, wrap_flag};
      duty_sel:     rd_word = {24'd0, shadow[duty_idx]};
      default:      rd_word = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
      ctrl        <= '0;
      prescale    <= PRESCALE_RST;
      wrap_flag   <= 1'b0;
    end else begin
      iomem_ready <= sel;
      if (sel) iomem_rdata <= rd_word;
      if (ctrl_we) ctrl <= iomem_wdata[2:0];
      if (pre_we0) prescale[7:0] <= iomem_wdata[7:0];
      if (pre_we1) prescale[15:8] <= iomem_wdata[15:8];
      if (wrap) wrap_flag <= 1'b1;
      else if (stat_clr) wrap_flag <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (duty_we) shadow[duty_idx] <= iomem_wdata[7:0];
      if (!en || wrap) begin
        for (int i = 0; i < 8; i++) active[i] <= shadow[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt <= '0;
      cnt  <= '0;
    end else if (!en) begin
      pcnt <= '0;
      cnt  <= '0;
    end else begin
      pcnt <= tick ? 16'd0 : pcnt + 16'd1;
      if (tick) cnt <= (cnt == 8'd254) ? 8'd0 : cnt + 8'd1;
    end
  end

  always_comb begin
    raw = '0;
    for (int i = 0; i < 8; i++) raw[i] = (cnt < active[i]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pwm_out <= '0;
    else if (en) pwm_out <= raw ^ {8{inv}};
    else pwm_out <= {8{inv}};
  end

endmodule

// File: tb/tb_iomem_pwm_leds.sv
// Bench for iomem_pwm_leds: register vectors, PWM timing
// measured against duty*(prescale+1) arithmetic, irq and reset.
module tb_iomem_pwm_leds;

  localparam logic [31:0] B = 32'h0400_0000;
  localparam int LIM = 5000;

  logic        clk = 1'b0;
  logic        reset;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic [7:0]  pwm_out;
  logic        irq;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  iomem_pwm_leds dut (
    .clk         (clk),
    .reset       (reset),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .pwm_out     (pwm_out),
    .irq         (irq)
  );

  typedef struct {
    logic [7:0]  ofs;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic bus(input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] d, output logic [31:0] r);
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = a;
    iomem_wstrb = s;
    iomem_wdata = d;
    @(posedge clk);
    #1;
    chk("ack", {31'd0, iomem_ready}, 32'd1);
    r = iomem_rdata;
    @(negedge clk);
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
  endtask

  task automatic run_len(input int ch, input bit inv, input bit lvl,
                         output int len);
    len = 1;
    for (int n = 0; n < LIM; n++) begin
      @(posedge clk);
      #1;
      if ((pwm_out[ch] ^ inv) != lvl) break;
      len++;
    end
  endtask

  task automatic measure(input int ch, input bit inv,
                         output int h1, output int l1, output int h2);
    bit prev, cur, ok;
    ok = 1'b0;
    cur = pwm_out[ch] ^ inv;
    for (int n = 0; n < LIM; n++) begin
      @(posedge clk);
      #1;
      prev = cur;
      cur = pwm_out[ch] ^ inv;
      if (!prev && cur) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rise_seen", {31'd0, ok}, 32'd1);
    run_len(ch, inv, 1'b1, h1);
    run_len(ch, inv, 1'b0, l1);
    run_len(ch, inv, 1'b1, h2);
  endtask

  vec_t vt[22];
  logic [31:0] r;
  int h1, l1, h2;
  int acks, c1, c2, k;
  logic [3:0] pat;
  int duty_m[8];
  int pre_m, ctrl_m, ch, d, p;
  bit inv;

  function automatic vec_t mk(input logic [7:0] o, input logic [3:0] s,
                              input logic [31:0] w, input logic [31:0] e);
    vec_t v;
    v.ofs = o; v.strb = s; v.wdata = w; v.exp = e;
    return v;
  endfunction

  initial begin
    reset = 1'b1;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    iomem_addr = '0;
    iomem_wdata = '0;

    vt[0]  = mk(8'h00, 4'h0, 32'h0, 32'h0);
    vt[1]  = mk(8'h04, 4'h0, 32'h0, 32'h0);
    vt[2]  = mk(8'h08, 4'h0, 32'h0, 32'h0);
    vt[3]  = mk(8'h1C, 4'h0, 32'h0, 32'h0);
    vt[4]  = mk(8'h1C, 4'h1, 32'hAB, 32'h0);
    vt[5]  = mk(8'h1C, 4'h0, 32'h0, 32'hAB);
    vt[6]  = mk(8'h1C, 4'hE, 32'h1234_5600, 32'hAB);
    vt[7]  = mk(8'h1C, 4'h0, 32'h0, 32'hAB);
    vt[8]  = mk(8'h04, 4'h1, 32'hBEEF, 32'h0);
    vt[9]  = mk(8'h04, 4'h0, 32'h0, 32'h00EF);
    vt[10] = mk(8'h04, 4'h2, 32'h1200, 32'h00EF);
    vt[11] = mk(8'h04, 4'h0, 32'h0, 32'h12EF);
    vt[12] = mk(8'h0C, 4'hF, 32'hFFFF_FFFF, 32'h0);
    vt[13] = mk(8'h0C, 4'h0, 32'h0, 32'h0);
    vt[14] = mk(8'h04, 4'hF, 32'h0, 32'h12EF);
    vt[15] = mk(8'h1C, 4'hF, 32'h0, 32'hAB);
    vt[16] = mk(8'h30, 4'h0, 32'h0, 32'h0);
    vt[17] = mk(8'h08, 4'h1, 32'h1, 32'h0);
    vt[18] = mk(8'h2C, 4'h1, 32'h5A, 32'h0);
    vt[19] = mk(8'h2C, 4'h0, 32'h0, 32'h5A);
    vt[20] = mk(8'h00, 4'h1, 32'hF8, 32'h0);
    vt[21] = mk(8'h00, 4'h0, 32'h0, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, iomem_ready}, 32'd0);
    chk("rst_rdata", iomem_rdata, 32'd0);
    chk("rst_pwm", {24'd0, pwm_out}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 22; i++) begin
      bus(B | {24'd0, vt[i].ofs}, vt[i].strb, vt[i].wdata, r);
      chk($sformatf("vec%0d", i), r, vt[i].exp);
    end

    // foreign address must never be acknowledged
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr = 32'h0300_0000;
    acks = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (iomem_ready) acks++;
    end
    @(negedge clk);
    iomem_valid = 1'b0;
    chk("noack", acks, 0);

    // held request is acked every other cycle
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr = B | 32'h04;
    pat = '0;
    repeat (4) begin
      @(posedge clk);
      #1;
      pat = {pat[2:0], iomem_ready};
    end
    @(negedge clk);
    iomem_valid = 1'b0;
    chk("b2b", {28'd0, pat}, 32'hA);

    bus(B | 32'h10, 4'h1, 32'd128, r);
    bus(B | 32'h14, 4'h1, 32'd0, r);
    bus(B | 32'h18, 4'h1, 32'd255, r);
    bus(B | 32'h00, 4'h1, 32'd1, r);
    measure(0, 1'b0, h1, l1, h2);
    chk("p0_high", h1, 128);
    chk("p0_low", l1, 127);
    chk("p0_high2", h2, 128);
    c1 = 0;
    c2 = 0;
    repeat (300) begin
      @(posedge clk);
      #1;
      if (pwm_out[1]) c1++;
      if (pwm_out[2]) c2++;
    end
    chk("duty0_low", c1, 0);
    chk("duty255_high", c2, 300);

    bus(B | 32'h00, 4'h1, 32'd0, r);
    bus(B | 32'h04, 4'h3, 32'd3, r);
    bus(B | 32'h10, 4'h1, 32'd10, r);
    bus(B | 32'h00, 4'h1, 32'd1, r);
    measure(0, 1'b0, h1, l1, h2);
    chk("p3_high", h1, 40);
    chk("p3_period", h1 + l1, 1020);

    // duty change mid-period only lands at the next wrap
    bus(B | 32'h00, 4'h1, 32'd0, r);
    bus(B | 32'h04, 4'h3, 32'd0, r);
    bus(B | 32'h10, 4'h1, 32'd128, r);
    bus(B | 32'h00, 4'h1, 32'd1, r);
    fork
      measure(0, 1'b0, h1, l1, h2);
      begin : wr
        logic [31:0] rr;
        int kk;
        kk = 0;
        while (!pwm_out[0] && kk < 10) begin
          @(posedge clk);
          #1;
          kk++;
        end
        repeat (45) @(posedge clk);
        bus(B | 32'h10, 4'h1, 32'd16, rr);
      end
    join
    chk("mid_cur_high", h1, 128);
    chk("mid_cur_low", l1, 127);
    chk("mid_next_high", h2, 16);

    bus(B | 32'h00, 4'h1, 32'd0, r);
    bus(B | 32'h00, 4'h1, 32'd7, r);
    k = 0;
    while (!irq && k < 600) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("irq_wrap", {31'd0, irq}, 32'd1);
    bus(B | 32'h08, 4'h0, 32'd0, r);
    chk("status_set", r, 32'd1);
    bus(B | 32'h08, 4'h1, 32'd1, r);
    chk("w1c_irq", {31'd0, irq}, 32'd0);
    bus(B | 32'h08, 4'h0, 32'd0, r);
    chk("status_clr", r, 32'd0);
    k = 0;
    while (!irq && k < 600) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("irq_wrap2", {31'd0, irq}, 32'd1);
    // next wrap is exactly 255 clocks later; aim the W1C at it
    repeat (254) @(posedge clk);
    bus(B | 32'h08, 4'h1, 32'd1, r);
    bus(B | 32'h08, 4'h0, 32'd0, r);
    chk("set_wins", r, 32'd1);
    chk("set_wins_irq", {31'd0, irq}, 32'd1);

    bus(B | 32'h00, 4'h1, 32'd0, r);
    bus(B | 32'h04, 4'h3, 32'd0, r);
    for (int i = 0; i < 8; i++) begin
      bus(B | (32'h10 + 32'(i * 4)), 4'h1, 32'd0, r);
      duty_m[i] = 0;
    end
    pre_m = 0;
    ctrl_m = 0;
    for (int it = 0; it < 6; it++) begin
      p = int'($urandom_range(5, 0));
      ch = int'($urandom_range(7, 0));
      inv = 1'($urandom_range(1, 0));
      bus(B | 32'h00, 4'h1, 32'd0, r);
      chk($sformatf("rnd%0d_ctrl", it), r, 32'(ctrl_m));
      ctrl_m = 0;
      bus(B | 32'h04, 4'h3, 32'(p), r);
      chk($sformatf("rnd%0d_pre", it), r, 32'(pre_m));
      pre_m = p;
      for (int i = 0; i < 8; i++) begin
        d = (i == ch) ? int'($urandom_range(254, 1))
                      : int'($urandom_range(255, 0));
        bus(B | (32'h10 + 32'(i * 4)), 4'h1, $urandom & 32'hFFFF_FF00
            | 32'(d), r);
        chk($sformatf("rnd%0d_duty%0d", it, i), r, 32'(duty_m[i]));
        duty_m[i] = d;
      end
      bus(B | 32'h00, 4'h1, {30'd0, inv, 1'b1}, r);
      chk($sformatf("rnd%0d_ctrl0", it), r, 32'(ctrl_m));
      ctrl_m = {inv, 1'b1};
      measure(ch, inv, h1, l1, h2);
      chk($sformatf("rnd%0d_high", it), h1, duty_m[ch] * (p + 1));
      chk($sformatf("rnd%0d_low", it), l1,
          (255 - duty_m[ch]) * (p + 1));
    end

    bus(B | 32'h00, 4'h1, 32'd2, r);
    @(posedge clk);
    #1;
    chk("dis_inv", {24'd0, pwm_out}, 32'hFF);

    bus(B | 32'h00, 4'h1, 32'd0, r);
    bus(B | 32'h10, 4'h1, 32'd200, r);
    bus(B | 32'h00, 4'h1, 32'd1, r);
    repeat (20) @(posedge clk);
    #1;
    chk("pre_rst_pwm0", {31'd0, pwm_out[0]}, 32'd1);
    bus(B | 32'h10, 4'h0, 32'd0, r);
    chk("pre_rst_duty0", r, 32'd200);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_pwm", {24'd0, pwm_out}, 32'd0);
    chk("arst_rdata", iomem_rdata, 32'd0);
    chk("arst_irq", {31'd0, irq}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus(B | 32'h00, 4'h0, 32'd0, r);
    chk("post_ctrl", r, 32'd0);
    bus(B | 32'h04, 4'h0, 32'd0, r);
    chk("post_pre", r, 32'd0);
    bus(B | 32'h08, 4'h0, 32'd0, r);
    chk("post_status", r, 32'd0);
    bus(B | 32'h10, 4'h0, 32'd0, r);
    chk("post_duty0", r, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("post_pwm", {24'd0, pwm_out}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
